// File: rtl/regfile_dump_reader.sv
// Register-file dump sequencer: walks an index range on one read port
// and streams {index, word} pairs out over a valid/ready handshake.
module regfile_dump_reader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit SKIP_R0 = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] select_reg_A,
  input  logic [DATA_W-1:0] data_mux_A,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] span;
  logic              slot_free;
  logic              skip;
  logic              last;

  assign span      = last_reg - first_reg;
  assign slot_free = !out_valid || out_ready;
  assign skip      = SKIP_R0 && (cur == '0);
  assign last      = (remaining == (ADDR_W+1)'(1));

  // The read port follows the walk pointer, so data_mux_A is settled
  // a full cycle before it is captured.
  assign select_reg_A = cur;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cur       <= first_reg;
            remaining <= {1'b0, span} + (ADDR_W+1)'(1);
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (abort) begin
            state <= DRAIN;
          end else if (skip || slot_free) begin
            // r0 is stepped over without occupying the output slot
            if (!skip) begin
              out_valid <= 1'b1;
              out_index <= cur;
              out_data  <= data_mux_A;
            end
            cur       <= cur + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (slot_free) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: two instances (SKIP_R0 off/on) share
// stimulus; every transferred word is checked against a range model.
module tb_regfile_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n, start, abort, out_ready;
  logic [AW-1:0] first_reg, last_reg;
  logic [AW-1:0] sel0, sel1, idx0, idx1;
  logic [DW-1:0] dat0, dat1, mux0, mux1;
  logic v0, v1, b0, b1, d0, d1;
  logic [DW-1:0] rf [32];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] dat;
  } word_t;
  word_t q0[$];
  word_t q1[$];
  word_t w0, w1;

  typedef struct {
    logic [AW-1:0] f;
    logic [AW-1:0] l;
    int mode;
    int n0;
    int n1;
  } vec_t;
  vec_t tbl[8];

  int n0 = 0, n1 = 0, done0 = 0, done1 = 0;
  int first0 = -1, dcyc0 = 0, dcyc1 = 0;
  bit aborting = 0;
  bit hold0 = 0, hold1 = 0;
  logic [AW-1:0] hidx0, hidx1;
  logic [DW-1:0] hdat0, hdat1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux0 = rf[sel0];
  assign mux1 = rf[sel1];

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .SKIP_R0(1'b0)) u0 (
    .Clk(clk), .Rst_n(rst_n), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .select_reg_A(sel0), .data_mux_A(mux0),
    .out_valid(v0), .out_ready(out_ready),
    .out_index(idx0), .out_data(dat0),
    .busy(b0), .done(d0)
  );

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .SKIP_R0(1'b1)) u1 (
    .Clk(clk), .Rst_n(rst_n), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg),
    .select_reg_A(sel1), .data_mux_A(mux1),
    .out_valid(v1), .out_ready(out_ready),
    .out_index(idx1), .out_data(dat1),
    .busy(b1), .done(d1)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Model: the indices first..last modulo 32, r0 removed when skipped.
  task automatic expect_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
    int fi, li, cnt;
    fi = int'(f);
    li = int'(l);
    cnt = ((li - fi) % 32 + 32) % 32 + 1;
    for (int k = 0; k < cnt; k++) begin
      int i;
      i = (fi + k) % 32;
      q0.push_back('{AW'(i), rf[i]});
      if (i != 0) q1.push_back('{AW'(i), rf[i]});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = 0;
    end else begin
      if (hold0) chk("u0 stall hold", {v0, idx0, dat0}, {1'b1, hidx0, hdat0});
      if (v0 && first0 < 0) first0 = cyc;
      if (v0 && out_ready) begin
        chk("u0 word expected", q0.size() > 0, 1);
        if (q0.size() > 0) begin
          w0 = q0.pop_front();
          chk("u0 index", idx0, w0.idx);
          chk("u0 data", dat0, w0.dat);
        end
        n0++;
      end
      if (d0) begin
        done0++;
        dcyc0 = cyc;
        if (!aborting) chk("u0 drained", q0.size(), 0);
      end
      hold0 = v0 && !out_ready;
      hidx0 = idx0;
      hdat0 = dat0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold1 = 0;
    end else begin
      if (hold1) chk("u1 stall hold", {v1, idx1, dat1}, {1'b1, hidx1, hdat1});
      if (v1 && out_ready) begin
        chk("u1 word expected", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          w1 = q1.pop_front();
          chk("u1 index", idx1, w1.idx);
          chk("u1 data", dat1, w1.dat);
        end
        n1++;
      end
      if (d1) begin
        done1++;
        dcyc1 = cyc;
        if (!aborting) chk("u1 drained", q1.size(), 0);
      end
      hold1 = v1 && !out_ready;
      hidx1 = idx1;
      hdat1 = dat1;
    end
  end

  // mode 0: ready=1, 1: random ready, 2: ready 1,0,0,1 then 1
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                          input int mode, input int abort_at, output int c0);
    int bd0, bd1;
    bd0 = done0;
    bd1 = done1;
    c0 = 0;
    first_reg = f;
    last_reg = l;
    expect_range(f, l);
    first0 = -1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) c0 = cyc;
      if (mode == 2 && (k == 2 || k == 3))
        chk("stalled first word", {v0, dat0}, {1'b1, rf[f]});
      if (done0 > bd0 && done1 > bd1) break;
      start = (k == 0);
      abort = (k == abort_at);
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = !(k == 1 || k == 2);
    end
    start = 1'b0;
    abort = 1'b0;
    chk("dump done", done0 > bd0 && done1 > bd1, 1);
    chk("idle after done", {b0, b1}, 2'b00);
  endtask

  initial begin
    int c0, s0, s1;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    first_reg = '0;
    last_reg = '0;
    for (int i = 0; i < 32; i++) rf[i] = DW'(i + 100);
    tbl[0] = '{5'd0, 5'd31, 0, 32, 31};
    tbl[1] = '{5'd5, 5'd5, 0, 1, 1};
    tbl[2] = '{5'd30, 5'd1, 0, 4, 3};
    tbl[3] = '{5'd2, 5'd4, 2, 3, 3};
    tbl[4] = '{5'd31, 5'd1, 0, 3, 2};
    tbl[5] = '{5'd0, 5'd0, 0, 1, 0};
    tbl[6] = '{5'd7, 5'd6, 1, 32, 31};
    tbl[7] = '{5'd1, 5'd0, 1, 32, 31};

    repeat (2) @(posedge clk);
    #1;
    chk("reset u0 outs", {v0, b0, d0, idx0, dat0, sel0}, '0);
    chk("reset u1 outs", {v1, b1, d1, idx1, dat1, sel1}, '0);
    rst_n = 1'b1;

    // full dump timing
    s0 = n0;
    run_dump(5'd0, 5'd31, 0, -1, c0);
    chk("first valid latency", first0 - c0, 2);
    chk("u0 done cycle", dcyc0 - c0, 34);
    chk("u1 done cycle", dcyc1 - c0, 34);
    chk("full dump words", n0 - s0, 32);

    for (int i = 0; i < 8; i++) begin
      s0 = n0;
      s1 = n1;
      run_dump(tbl[i].f, tbl[i].l, tbl[i].mode, -1, c0);
      chk("u0 word count", n0 - s0, tbl[i].n0);
      chk("u1 word count", n1 - s1, tbl[i].n1);
      if (i == 1) chk("single done timing", dcyc0 - c0, 3);
    end

    // abort right after the first transfer
    aborting = 1;
    s0 = n0;
    s1 = n1;
    run_dump(5'd0, 5'd31, 0, 3, c0);
    chk("u0 abort words", (n0 - s0) >= 1 && (n0 - s0) <= 2, 1);
    chk("u1 abort words", (n1 - s1) >= 1 && (n1 - s1) <= 2, 1);
    q0.delete();
    q1.delete();
    aborting = 0;

    // reset while a word is stalled at the output
    first_reg = 5'd0;
    last_reg = 5'd31;
    expect_range(5'd0, 5'd31);
    @(posedge clk);
    #1;
    start = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset valid", {v0, b0}, 2'b11);
    s0 = done0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid-dump reset u0", {v0, b0, d0}, 3'b000);
    chk("mid-dump reset u1", {v1, b1, d1}, 3'b000);
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    chk("no done on reset", done0 - s0, 0);
    s0 = n0;
    run_dump(5'd3, 5'd9, 1, -1, c0);
    chk("post-reset words", n0 - s0, 7);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      run_dump(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
               1, -1, c0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
